// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of in-flight branch predictions, matched
// against execute outcomes to produce branch history table updates and a
// mispredict redirect that flushes all younger in-flight branches.
// Optional build macro BRANCH_RESOLVE_STATS_EN adds saturating resolve and
// mispredict counters (stat_resolved, stat_mispred).
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push_valid,
  input  logic [IDX_W-1:0]         push_idx,
  input  logic                     push_pred,
  input  logic [PC_W-1:0]          push_alt_pc,
  output logic                     push_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_idx,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [15:0]              stat_resolved,
  output logic [15:0]              stat_mispred,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic [PC_W-1:0]  alt_pc;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]   count_d;
  logic               push_acc, res_acc, mis, do_write;
  entry_t             head;

  // Accept/flush decisions and next pointer/count state
  always_comb begin
    push_acc = push_valid && (count != CNT_W'(DEPTH));
    res_acc  = res_valid && (count != '0);
    head     = mem[rd_ptr];
    mis      = res_acc && (res_taken != head.pred);
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    do_write = 1'b0;
    if (mis) begin
      // Wrong-path entries and any same-cycle push are dropped
      rd_ptr_d = wr_ptr;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        do_write = 1'b1;
        wr_ptr_d = wr_ptr + PTR_W'(1);
      end
      if (res_acc) begin
        rd_ptr_d = rd_ptr + PTR_W'(1);
      end
      count_d = count + CNT_W'(push_acc) - CNT_W'(res_acc);
    end
  end

  // FIFO pointers, occupancy and entry storage
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      push_ready <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      count      <= count_d;
      push_ready <= (count_d != CNT_W'(DEPTH));
      if (do_write) begin
        mem[wr_ptr] <= '{idx: push_idx, pred: push_pred, alt_pc: push_alt_pc};
      end
    end
  end

  // Registered table update and redirect outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_valid  <= res_acc;
      mispredict <= mis;
      if (res_acc) begin
        upd_idx   <= head.idx;
        upd_taken <= res_taken;
      end
      if (mis) begin
        redirect_pc <= head.alt_pc;
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // Saturating resolve / mispredict counters
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_acc && (stat_resolved != 16'hFFFF)) begin
        stat_resolved <= stat_resolved + 16'd1;
      end
      if (mis && (stat_mispred != 16'hFFFF)) begin
        stat_mispred <= stat_mispred + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the branch history table, which is read by fetch.
- Holds an in-order queue of in-flight branch predictions issued by fetch, matches each against the actual outcome from execute, and produces the table update (write enable, index, taken).
- Raises a one-cycle mispredict/redirect to the front end and discards all younger in-flight branches.

Parameters:
DEPTH, 4, number of in-flight branch entries (power of 2, >=2)
IDX_W, 5, width of the table index (low PC bits)
PC_W, 32, program counter width

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
push_valid  in  1  fetch issues a predicted branch this cycle
push_idx  in  IDX_W  table index of the branch
push_pred  in  1  predicted direction (1 = taken)
push_alt_pc  in  PC_W  PC of the path not chosen by the prediction
push_ready  out  1  queue not full; push accepted only when push_valid && push_ready
res_valid  in  1  execute resolves the oldest in-flight branch
res_taken  in  1  actual direction
upd_valid  out  1  table write enable
upd_idx  out  IDX_W  table write address
upd_taken  out  1  table update outcome
mispredict  out  1  one-cycle redirect pulse
redirect_pc  out  PC_W  fetch restart PC, valid while mispredict=1
count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: asynchronous, asserted by arst_n low. Clears pointers and count, so count=0 and push_ready=1. Forces upd_valid=0, upd_idx=0, upd_taken=0, mispredict=0 and redirect_pc=0. All entry storage is cleared to 0.
- Storage: circular FIFO of DEPTH entries {idx, pred, alt_pc}.
- Pointers: wr_ptr and rd_ptr wrap modulo DEPTH. count is tracked separately.
- push_ready = (count != DEPTH), driven from registered state only. A push while full is ignored, even if a resolve occurs in the same cycle.
- Resolve: a resolve is accepted when res_valid && count != 0. It pops the head. res_valid while empty is ignored: no update and no pulse.
- Update latency: 1 cycle. In cycle N+1 after an accepted resolve:
  - upd_valid=1
  - upd_idx = head.idx
  - upd_taken = res_taken
- Mispredict latency: 1 cycle. In cycle N+1 after an accepted resolve with res_taken != head.pred:
  - mispredict=1
  - redirect_pc = head.alt_pc
- All outputs are registered. upd_valid and mispredict are single-cycle pulses; redirect_pc holds its value between mispredicts.
- Flush on mispredict: in cycle N itself, when the mismatch is detected, all remaining entries are discarded (count becomes 0, rd_ptr = wr_ptr). A push in the same cycle N is also dropped, because it belongs to the wrong path.
- Simultaneous push and correct resolve: count is unchanged; both pointers advance.
- Simultaneous push and resolve at count=1: legal. The pushed entry becomes the head in N+1.
- No internal state machine beyond the FIFO. The entry valid state is implied by count.
- Width rule: count has clog2(DEPTH)+1 bits so it can represent DEPTH.

Optional Feature:
Macro: BRANCH_RESOLVE_STATS_EN
- Defined: adds two outputs, stat_resolved[15:0] and stat_mispred[15:0].
  - These are saturating counters (they stick at 16'hFFFF) of accepted resolves and of mispredicts.
  - Both are cleared by arst_n and updated in the same cycle as upd_valid and mispredict.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset mid-traffic: fill 3 entries, pulse arst_n low → count=0, push_ready=1, no upd_valid/mispredict, all outputs 0.
- Correct prediction: push idx=5, pred=1, alt=0x100; resolve taken=1 → next cycle upd_valid=1, upd_idx=5, upd_taken=1, mispredict=0, count=0.
- Mispredict flush: push idx 1,2,3 (pred=0, alt=0x40,0x80,0xC0); resolve taken=1 while pushing idx 4 → next cycle mispredict=1, redirect_pc=0x40, upd_idx=1, count=0; push of idx 4 lost.
- Full boundary: push 4 entries → push_ready=0. Push idx 9 together with a correct resolve → idx 9 rejected, count=3.
- Wrap-around: 10 push/resolve pairs with alternating outcomes matching the prediction → upd_idx sequence equals push order, no mispredict.
- Empty resolve: res_valid=1 with count=0 → no upd_valid, no mispredict. With BRANCH_RESOLVE_STATS_EN, stat_resolved is unchanged.
